// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM generator driving 16 pins, each forced low, forced high, or following the waveform.
// The duty cycle is captured into a shadow register only at the period wrap, so the waveform never glitches mid-period.
module pwm_peripheral #(
  parameter int CLK_DIV = 3000,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] en_reg_out,
  input  logic [15:0] en_reg_pwm,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  localparam logic [CNT_W-1:0] LP_DIV_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_prescaler;
  logic [7:0]       r_count;
  logic [7:0]       r_duty_shadow;
  logic [15:0]      r_pwm_out;
  logic             r_period_start;

  logic             w_tick;
  logic             w_wrap;
  logic             w_pwm_raw;
  logic [15:0]      w_pwm_next;

  assign w_tick = (r_prescaler == LP_DIV_MAX);
  assign w_wrap = w_tick && (r_count == 8'hFF);

  // 0xFF is special-cased so full scale is a true 100% with no low clock at the wrap.
  assign w_pwm_raw  = (r_duty_shadow == 8'hFF) || (r_count < r_duty_shadow);
  assign w_pwm_next = en_reg_out & (~en_reg_pwm | {16{w_pwm_raw}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescaler    <= '0;
      r_count        <= 8'h00;
      r_duty_shadow  <= 8'h00;
      r_pwm_out      <= 16'h0000;
      r_period_start <= 1'b0;
    end else begin
      r_prescaler    <= w_tick ? '0 : r_prescaler + CNT_W'(1);
      if (w_tick) begin
        r_count <= r_count + 8'd1;
      end
      if (w_wrap) begin
        r_duty_shadow <= pwm_duty_cycle;
      end
      r_period_start <= w_wrap;
      r_pwm_out      <= w_pwm_next;
    end
  end

  assign pwm_out      = r_pwm_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed plus randomized bench for pwm_peripheral with CLK_DIV=4 (one period = 1024 clocks).
// Expected pin values come from a cycle-index model: phase = clocks since reset mod period.
module tb_pwm_peripheral;

  localparam int DIV    = 4;
  localparam int PERIOD = 256 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_reg_out = 16'h0000;
  logic [15:0] en_reg_pwm = 16'h0000;
  logic [7:0]  pwm_duty_cycle = 8'h00;
  logic [15:0] pwm_out;
  logic        period_start;

  int checks = 0;
  int fails  = 0;
  int hi_cnt = 0;
  int ps_cnt = 0;
  int ps_at  = 0;
  int cyc    = 0;

  // Reference model state: clocks since reset release and the duty owning the current period.
  int unsigned m_t = 0;
  logic [7:0]  m_duty = 8'h00;
  logic [15:0] exp_out = 16'h0000;
  logic        exp_ps = 1'b0;

  pwm_peripheral #(.CLK_DIV(DIV), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_reg_out     (en_reg_out),
    .en_reg_pwm     (en_reg_pwm),
    .pwm_duty_cycle (pwm_duty_cycle),
    .pwm_out        (pwm_out),
    .period_start   (period_start)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_out(input int unsigned t, input logic [7:0] d,
                                            input logic [15:0] eo, input logic [15:0] ep);
    int unsigned step;
    logic        raw;
    step = (t % PERIOD) / DIV;
    raw  = (d == 8'hFF) || (step < int'(d));
    return eo & (~ep | {16{raw}});
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t     <= 0;
      m_duty  <= 8'h00;
      exp_out <= 16'h0000;
      exp_ps  <= 1'b0;
    end else begin
      exp_out <= model_out(m_t, m_duty, en_reg_out, en_reg_pwm);
      exp_ps  <= ((m_t % PERIOD) == PERIOD - 1);
      if ((m_t % PERIOD) == PERIOD - 1) m_duty <= pwm_duty_cycle;
      m_t <= m_t + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_meas();
    hi_cnt = 0;
    ps_cnt = 0;
    ps_at  = 0;
    cyc    = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      check("pwm_out", pwm_out, exp_out);
      check("period_start", {15'b0, period_start}, {15'b0, exp_ps});
      if (pwm_out[0]) hi_cnt++;
      if (period_start) begin
        ps_cnt++;
        ps_at = cyc;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", pwm_out, 16'h0000);
    check("reset_period_start", {15'b0, period_start}, 16'h0000);

    en_reg_out = 16'hFFFF;
    en_reg_pwm = 16'h0000;
    rst = 1'b0;
    run(1);
    check("forced_high", pwm_out, 16'hFFFF);
    run(20);

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out", pwm_out, 16'h0000);
    check("async_reset_ps", {15'b0, period_start}, 16'h0000);
    @(negedge clk);
    @(negedge clk);

    en_reg_out = 16'h0001;
    en_reg_pwm = 16'h0001;
    pwm_duty_cycle = 8'h80;
    rst = 1'b0;
    clear_meas();
    run(PERIOD);
    check("first_period_high", 16'(hi_cnt), 16'd0);
    check("first_period_ps_cnt", 16'(ps_cnt), 16'd1);
    check("first_period_ps_at", 16'(ps_at), 16'(PERIOD));
    clear_meas();
    run(PERIOD);
    check("duty80_high", 16'(hi_cnt), 16'd512);
    check("duty80_ps_at", 16'(ps_at), 16'(PERIOD));

    pwm_duty_cycle = 8'h00;
    run(PERIOD);
    clear_meas();
    run(PERIOD);
    check("duty00_high", 16'(hi_cnt), 16'd0);

    pwm_duty_cycle = 8'hFF;
    run(PERIOD);
    clear_meas();
    run(2 * PERIOD);
    check("dutyFF_high", 16'(hi_cnt), 16'(2 * PERIOD));

    pwm_duty_cycle = 8'h01;
    run(PERIOD);
    clear_meas();
    run(PERIOD);
    check("duty01_high", 16'(hi_cnt), 16'd4);

    pwm_duty_cycle = 8'h40;
    run(PERIOD);
    clear_meas();
    run(400);
    pwm_duty_cycle = 8'hC0;
    run(PERIOD - 400);
    check("midchange_cur_high", 16'(hi_cnt), 16'd256);
    clear_meas();
    run(PERIOD);
    check("midchange_next_high", 16'(hi_cnt), 16'd768);

    en_reg_out = 16'hFFFF;
    en_reg_pwm = 16'hFFFF;
    pwm_duty_cycle = 8'($urandom_range(1, 254));
    run(PERIOD);
    run(300);
    en_reg_out = 16'h00FF;
    run(1);
    check("en_drop_upper", {8'h00, pwm_out[15:8]}, 16'h0000);
    run(500);
    run(PERIOD - 801);

    en_reg_out = 16'h0001;
    en_reg_pwm = 16'h0001;
    pwm_duty_cycle = 8'hFF;
    run(802);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrun_reset_out", pwm_out, 16'h0000);
    rst = 1'b0;
    clear_meas();
    run(PERIOD);
    check("post_reset_high", 16'(hi_cnt), 16'd0);
    check("post_reset_ps_cnt", 16'(ps_cnt), 16'd1);
    check("post_reset_ps_at", 16'(ps_at), 16'(PERIOD));
    clear_meas();
    run(PERIOD);
    check("post_reset_ff_high", 16'(hi_cnt), 16'(PERIOD));

    for (int k = 0; k < 8; k++) begin
      pwm_duty_cycle = 8'($urandom_range(0, 255));
      en_reg_out     = 16'($urandom);
      en_reg_pwm     = 16'($urandom);
      run($urandom_range(1, 1500));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the five configuration bytes written by the SPI register block and drives 16 output pins. Each pin can be forced low, forced high, or driven by a shared 8-bit PWM waveform. It sits directly downstream of the SPI register file and directly upstream of the uo_out/uio_out pad muxing. It runs in the system clock domain, and the duty cycle is applied glitch-free at period boundaries.

Parameters:
CLK_DIV, 3000, system clocks per PWM count step (10 MHz / 3000 / 256 ≈ 13 Hz period); legal range 2..65535
CNT_W, 16, prescaler counter width; must hold CLK_DIV-1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en_reg_out  input  16  per-pin output enable; bits 7:0 = SPI reg 0x00, bits 15:8 = reg 0x01
en_reg_pwm  input  16  per-pin PWM select; bits 7:0 = reg 0x02, bits 15:8 = reg 0x03
pwm_duty_cycle  input  8  duty cycle, reg 0x04
pwm_out  output  16  pin drive; bits 7:0 to uo_out, bits 15:8 to uio_out
period_start  output  1  one-clock pulse on the first clock of each PWM period

Behaviour:
- Reset (rst=1, asynchronous, any time, including mid-period):
  - prescaler=0, count=0, duty_shadow=0x00.
  - pwm_out=0, period_start=0.
  - All counting resumes on the first rising clk after rst deasserts.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick = (prescaler == CLK_DIV-1).
- Count:
  - 8-bit; increments on tick; wraps 255 -> 0 on tick.
  - One PWM period = 256*CLK_DIV clocks.
- Duty shadow:
  - duty_shadow <= pwm_duty_cycle on the clock where tick=1 and count=255 (period wrap).
  - Changes to pwm_duty_cycle mid-period have no effect until the next wrap.
  - The first period after reset always uses duty 0x00.
- period_start: registered; asserted for exactly one clock, the clock after the wrap edge, i.e. when count=0 and prescaler=0. Not asserted during reset or on the first clock after reset release.
- pwm_raw (combinational):
  - duty_shadow == 0xFF -> 1 (100% high).
  - Otherwise -> count < duty_shadow.
  - 0x00 -> 0%; 0x80 -> high for count 0..127.
  - High time = duty_shadow/256 of the period, except 0xFF = 256/256.
- Per pin i, registered (one clock latency from inputs/counters):
  - en_reg_out[i]=0 -> pwm_out[i]=0, regardless of en_reg_pwm[i].
  - en_reg_out[i]=1, en_reg_pwm[i]=0 -> pwm_out[i]=1.
  - en_reg_out[i]=1, en_reg_pwm[i]=1 -> pwm_out[i]=pwm_raw.
- Enable registers are not shadowed: an enable change is visible on pwm_out exactly one clock later, mid-period allowed.
- All PWM pins are phase-aligned: rising edges occur together at count=0.
- Inputs are treated as quasi-static, single-domain signals. Upstream holds them stable; no synchronizers in this block.
- No FSM deadlock: counters are free-running; all states are reachable only via reset or counting.

Test Plan:
- CLK_DIV=4. Reset, then en_reg_out=0xFFFF, en_reg_pwm=0x0000 -> pwm_out=0xFFFF one clock after inputs settle; rst=1 mid-run -> pwm_out=0x0000 immediately (async, no clock edge).
- CLK_DIV=4, en_reg_out=en_reg_pwm=0x0001, duty=0x80 after reset:
  - First period (1024 clks): pwm_out[0]=0.
  - Second period: pwm_out[0] high 512 clks, low 512 clks.
  - period_start pulses every 1024 clks.
- duty=0x00 -> pwm_out[0] constant 0; duty=0xFF -> constant 1 across a full period, no low glitch at wrap; duty=0x01 -> high exactly 4 clks per period.
- Duty=0x40 established, write 0xC0 mid-period (count=100) -> current period keeps 256 high clks; next period 768 high clks; no runt pulse.
- en_reg_pwm=0xFFFF, en_reg_out toggled 0xFFFF -> 0x00FF mid-period -> pwm_out[15:8] drop to 0 next clock; pwm_out[7:0] continue the waveform unaffected and stay edge-aligned.
- Reset asserted at count=200, prescaler=2, held 3 clks, released -> count restarts at 0; first period_start occurs 1024 clks after release; duty_shadow=0 during that period.
